mod_mul_seq: RTL and testbench
==============================

MOD_MUL_SEQ -- requirements
Module: mod_mul_seq

Interface
REQ-001 SHALL have parameter W, default 48, the operand and modulus width in bits.
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on its rising edge.
REQ-003 SHALL have port rstn  input  1  reset; synchronous and active-low.
REQ-004 SHALL have port start  input  1  request to begin one multiplication.
REQ-005 SHALL have port A  input  W  multiplicand; caller guarantees A < q.
REQ-006 SHALL have port Bm  input  W  multiplier (twiddle); caller guarantees Bm < q.
REQ-007 SHALL have port q  input  W  modulus; caller guarantees q >= 2.
REQ-008 SHALL have port busy  output  1  high while an operation is in progress.
REQ-009 SHALL have port done  output  1  single-cycle pulse marking P valid.
REQ-010 SHALL have port P  output  W  result (A*Bm) mod q, fed to the downstream modular adder.

Function
REQ-011 SHALL implement an MSB-first interleaved modular multiplication: per step, acc = 2*acc + a_i*Bm, then subtract q at most twice until acc < q.
REQ-012 SHALL hold the internal accumulator at W+2 bits, so 3q-1 never overflows for any W-bit q.
REQ-013 SHALL implement FSM states IDLE, RUN, DONE; the reset state is IDLE.
REQ-014 SHALL, when start=1 at a rising edge in IDLE or DONE, latch A, Bm and q, clear acc and the bit counter, and enter RUN.
REQ-015 SHALL process one multiplier bit per cycle in RUN, bit W-1 first, and leave RUN after exactly W cycles.
REQ-016 SHALL, with start sampled at edge k, assert busy in cycles k+1 .. k+W and assert done with a valid P in cycle k+W+1 (default W=48: done in cycle k+49).
REQ-017 SHALL transition DONE -> IDLE after one cycle if start=0, or DONE -> RUN if start=1 (back-to-back operation, no bubble).
REQ-018 SHALL ignore start while in RUN; latched operands are not disturbed.
REQ-019 SHALL hold P stable from the done cycle until the next done pulse.
REQ-020 SHALL treat input changes on A, Bm and q outside the start edge as having no effect.
REQ-021 SHALL keep busy and done mutually exclusive and never high in IDLE.

Reset
REQ-022 SHALL, with rstn=0 at a rising edge, set state=IDLE, busy=0, done=0, P=0, acc=0 and counter=0.
REQ-023 SHALL, on reset during RUN, abort the operation with no done pulse; the first start after rstn returns high begins a fresh operation.
REQ-024 SHALL give reset priority over start when both are active at the same edge.

Configuration
REQ-025 SHALL support macro MOD_MUL_ZERO_SKIP_EN.
REQ-026 SHALL, when MOD_MUL_ZERO_SKIP_EN is defined and latched A==0 or Bm==0, skip RUN: go directly to DONE with P=0, so done appears in cycle k+1.
REQ-027 SHALL, when MOD_MUL_ZERO_SKIP_EN is undefined, use a fixed latency of W+1 cycles for all operands (REQ-016), including zero operands.

Verification
REQ-028 SHALL cover: W=48, A=5, Bm=7, q=13, start at edge k -> done in cycle k+49, P=9, busy high for exactly 48 cycles.
REQ-029 SHALL cover: q=2^48-59, A=Bm=q-1 -> P=1; accumulator shows no overflow.
REQ-030 SHALL cover: A=0, Bm=123, q=257 -> P=0; done in cycle k+1 with MOD_MUL_ZERO_SKIP_EN, in cycle k+49 without it.
REQ-031 SHALL cover: start pulsed again, with A changed to 1, at cycle k+10 -> ignored; P equals the first operation's result at k+49.
REQ-032 SHALL cover: start held high through DONE with new operands A=3, Bm=4, q=11 -> second done 49 cycles after the first, P=1.
REQ-033 SHALL cover: rstn=0 at cycle k+20 of an operation -> no done pulse; busy=0 and P=0 next cycle; a following operation produces the correct result.

Source files
------------

// File: rtl/mod_mul_seq.sv
// mod_mul_seq: MSB-first interleaved (A*Bm) mod q, one multiplier bit per cycle.
// Optional MOD_MUL_ZERO_SKIP_EN: zero operands bypass RUN and finish in one cycle.
module mod_mul_seq #(
  parameter int W = 48
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         start,
  input  logic [W-1:0] A,
  input  logic [W-1:0] Bm,
  input  logic [W-1:0] q,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] P
);
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W+1:0] acc_q, acc_d, t1, t2, t3, mq;
  logic [W-1:0] a_q, a_d, b_q, b_d, m_q, m_d, p_q, p_d;
  logic zero;
`ifdef MOD_MUL_ZERO_SKIP_EN
  assign zero = (A == '0) || (Bm == '0);
`else
  assign zero = 1'b0;
`endif
  // acc < q on entry, so 2*acc + Bm <= 3q-3 fits W+2 bits and two subtractions restore acc < q
  assign mq = {2'b0, m_q};
  assign t1 = (acc_q << 1) + (a_q[W-1] ? {2'b0, b_q} : '0);
  assign t2 = (t1 >= mq) ? t1 - mq : t1;
  assign t3 = (t2 >= mq) ? t2 - mq : t2;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    p_d     = p_q;
    if (state_q == RUN) begin
      acc_d = t3;
      a_d   = a_q << 1;
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == CW'(W - 1)) begin
        state_d = DONE;
        p_d     = t3[W-1:0];
      end
    end else if (start) begin
      a_d     = A;
      b_d     = Bm;
      m_d     = q;
      acc_d   = '0;
      cnt_d   = '0;
      state_d = zero ? DONE : RUN;
      p_d     = zero ? '0 : p_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      p_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      p_q     <= p_d;
    end
  end
  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign P    = p_q;
endmodule

// File: tb/tb_mod_mul_seq.sv
// tb_mod_mul_seq: directed checks of mod_mul_seq latency, results, restart and reset behaviour.
module tb_mod_mul_seq;
  localparam int W = 48;
  localparam logic [W-1:0] QBIG = 48'hFFFF_FFFF_FFC5;
`ifdef MOD_MUL_ZERO_SKIP_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = W + 1;
`endif
  logic clk = 0, rstn = 0, start = 0, busy, done;
  logic [W-1:0] A = '0, Bm = '0, q = '0, P;
  int n_cmp = 0, n_err = 0;
  mod_mul_seq #(.W(W)) dut (.clk(clk), .rstn(rstn), .start(start), .A(A), .Bm(Bm), .q(q),
                            .busy(busy), .done(done), .P(P));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] m);
    @(negedge clk);
    A = a; Bm = b; q = m; start = 1;
    @(posedge clk);
    #1 start = 0;
  endtask
  task automatic wait_done(output int n, output int bc, output int both);
    n = 0; bc = 0; both = 0;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (busy) bc++;
      if (busy && done) both++;
      if (done) break;
    end
  endtask
  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                    input logic [W-1:0] m, input logic [W-1:0] exp, input int lat);
    int n, bc, both;
    launch(a, b, m);
    A = '1; Bm = '1; q = '1;
    wait_done(n, bc, both);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_P"}, P, exp);
    chk({tag, "_busy"}, bc, lat - 1);
    chk({tag, "_excl"}, both, 0);
    @(negedge clk);
    chk({tag, "_hold"}, P, exp);
    chk({tag, "_idle"}, {busy, done}, 0);
  endtask
  initial begin
    int n, bc, both, cnt;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_P", P, 0);
    start = 1; A = 5; Bm = 7; q = 13;
    @(negedge clk);
    chk("rst_prio_busy", busy, 0);
    chk("rst_prio_done", done, 0);
    start = 0; rstn = 1;
    op("basic", 5, 7, 13, 9, W + 1);
    op("big", QBIG - 1, QBIG - 1, QBIG, 1, W + 1);
    op("pow", 48'h8000_0000_0000, 2, QBIG, 59, W + 1);
    op("mid", 100, 200, 257, 211, W + 1);
    op("zero", 0, 123, 257, 0, ZLAT);
    // restart request during RUN is ignored
    launch(5, 7, 13);
    repeat (9) @(negedge clk);
    A = 1; start = 1;
    @(posedge clk);
    #1 start = 0;
    wait_done(n, bc, both);
    chk("ign_lat", n + 9, W + 1);
    chk("ign_P", P, 9);
    // back-to-back: start held high into DONE
    launch(5, 7, 13);
    repeat (W) @(negedge clk);
    A = 3; Bm = 4; q = 11; start = 1;
    @(negedge clk);
    chk("b2b_done1", done, 1);
    chk("b2b_P1", P, 9);
    @(posedge clk);
    #1 start = 0;
    wait_done(n, bc, both);
    chk("b2b_lat", n, W + 1);
    chk("b2b_P2", P, 1);
    chk("b2b_busy", bc, W);
    // reset mid-operation aborts with no done
    launch(100, 200, 257);
    repeat (19) @(negedge clk);
    rstn = 0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_P", P, 0);
    chk("abort_done", done, 0);
    rstn = 1;
    cnt = 0;
    repeat (60) begin
      @(negedge clk);
      if (done || busy) cnt++;
    end
    chk("abort_quiet", cnt, 0);
    op("after", 100, 200, 257, 211, W + 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
